uart_cmd_bridge: RTL and testbench
==================================

# uart_cmd_bridge

Command parser between the UART byte receiver/transmitter and the SDRAM controller. Assembles read/write commands from the incoming byte stream, drives the controller's level-held request interface until completion, and returns read data or a status byte to the UART transmitter. It is the only master of the SDRAM controller's control interface.

## Interface
Parameters:
- TIMEOUT_CYCLES, 4096: maximum cycles a request is held without a completion pulse before it is aborted.

Ports:
- clk_100MHz  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_data  in  8  received UART byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid; held until accepted
- tx_ready  in  1  transmitter accepts the byte on a cycle with tx_valid=1
- addr  out  24  SDRAM word address to controller
- wr_data  out  16  write word to controller
- wr_req  out  1  write request, level, held until wr_ready
- rd_req  out  1  read request, level, held until rd_valid
- rd_data  in  16  read word from controller
- rd_valid  in  1  one-cycle read completion pulse
- wr_ready  in  1  one-cycle write completion pulse
- busy  out  1  high in every state except IDLE
- rx_dropped  out  1  one-cycle pulse when a byte arrives while busy in ISSUE/RESP

## Operation
- Protocol, all multi-byte fields MSB first:
  - write: 0x57 'W', A2, A1, A0, D1, D0. Response 0x4B 'K'.
  - read: 0x52 'R', A2, A1, A0. Response D1, D0.
  - any other opcode byte: response 0x3F '?'; byte discarded.
  - timeout: response 0x45 'E'.
- States: IDLE, GET_ADDR, GET_DATA, ISSUE_WR, ISSUE_RD, RESP.
- IDLE: rx_valid with 'W' or 'R' -> GET_ADDR, byte counter = 0, opcode latched; other opcode -> RESP with '?'.
- GET_ADDR: each rx_valid shifts byte into addr (addr <= {addr[15:0], rx_data}); on third byte -> GET_DATA for 'W', ISSUE_RD for 'R'.
- GET_DATA: shifts into wr_data; on second byte -> ISSUE_WR.
- ISSUE_WR/ISSUE_RD: wr_req/rd_req = 1, timeout counter runs. Completion pulse -> req = 0 next cycle, RESP. Counter reaching TIMEOUT_CYCLES-1 -> req = 0, RESP with 'E'.
- RESP: one or two response bytes in a 2-entry register; presents tx_valid until each is accepted by tx_ready; after last byte -> IDLE.
- addr and wr_data hold their values outside GET_ADDR/GET_DATA; never both rd_req and wr_req high.
- Bytes arriving in ISSUE_*/RESP are discarded with rx_dropped pulse. Bytes in GET_* never dropped.
- Completion pulses arriving in any state other than the matching ISSUE_* are ignored (late completion after timeout).
- Reset values: tx_data 0, tx_valid 0, addr 0, wr_data 0, wr_req 0, rd_req 0, busy 0, rx_dropped 0; state IDLE, counters 0. Reset mid-command discards partial command and drops any request immediately.

## Timing
- Last command byte strobed at cycle k -> req high from cycle k+1.
- Completion pulse at cycle m -> req low at m+1; tx_valid high at m+1 with first response byte.
- rd_data captured on the rd_valid cycle; not resampled later.
- '?' response: tx_valid high the cycle after the opcode strobe.
- Timeout: req asserted at cycle s -> req low and 'E' presented at s+TIMEOUT_CYCLES.
- tx transfer occurs on each edge with tx_valid & tx_ready; next byte (if any) presented the following cycle; IDLE entered the cycle after the last transfer.
- Timeout counter width = $clog2(TIMEOUT_CYCLES); cleared on each entry to ISSUE_*.

## Structure
- Shared package sdram_uart_pkg: opcode/response constants (0x57, 0x52, 0x4B, 0x45, 0x3F), state encoding, address/data widths (24, 16).
- Single module; the 2-byte response register with handshake is a natural sub-module, resp_tx_buf (load 1 or 2 bytes, valid/ready drain, empty flag).

## Test plan
- Write: bytes 57 12 34 56 AB CD -> addr=0x123456, wr_data=0xABCD, wr_req held until wr_ready pulse, then tx 0x4B.
- Read: 52 12 34 56, controller returns rd_data=0xBEEF with rd_valid after 6 cycles -> rd_req held 6 cycles, tx 0xBE then 0xEF.
- Unknown opcode 0x41 -> tx 0x3F, no request, back to IDLE.
- Timeout: read with controller silent, TIMEOUT_CYCLES=16 -> rd_req high exactly 16 cycles, tx 0x45; a later rd_valid is ignored.
- Backpressure and drop: tx_ready low 10 cycles during read response, byte 0x52 sent meanwhile -> rx_dropped pulse, both data bytes transmitted in order, no request issued.
- Reset mid-command: rst_n low after 57 12 -> all outputs 0; subsequent full write command executes correctly.

Source files
------------

// File: rtl/sdram_uart_pkg.sv
// Shared constants and types for the UART command bridge to the SDRAM controller.
package sdram_uart_pkg;

    localparam int unsigned AddrW = 24;
    localparam int unsigned DataW = 16;

    localparam logic [7:0] OpWrite = 8'h57;
    localparam logic [7:0] OpRead  = 8'h52;
    localparam logic [7:0] RespOk  = 8'h4B;
    localparam logic [7:0] RespErr = 8'h45;
    localparam logic [7:0] RespUnk = 8'h3F;

    typedef enum logic [2:0] {
        StIdle,
        StGetAddr,
        StGetData,
        StIssueWr,
        StIssueRd,
        StResp
    } state_e;

endpackage

// File: rtl/resp_tx_buf.sv
// Two-entry response byte register drained over a valid/ready handshake.
module resp_tx_buf (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic       load,
    input  logic       load_two,
    input  logic [7:0] byte0,
    input  logic [7:0] byte1,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       empty,
    output logic       last_xfer
);

    logic [1:0] cnt_q, cnt_d;
    logic [7:0] buf0_q, buf0_d;
    logic [7:0] buf1_q, buf1_d;

    always_comb begin
        cnt_d  = cnt_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (load) begin
            buf0_d = byte0;
            buf1_d = byte1;
            cnt_d  = load_two ? 2'd2 : 2'd1;
        end else if (tx_valid && tx_ready) begin
            buf0_d = buf1_q;
            cnt_d  = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            buf0_q <= 8'h00;
            buf1_q <= 8'h00;
        end else begin
            cnt_q  <= cnt_d;
            buf0_q <= buf0_d;
            buf1_q <= buf1_d;
        end
    end

    assign tx_data   = buf0_q;
    assign tx_valid  = (cnt_q != 2'd0);
    assign empty     = (cnt_q == 2'd0);
    assign last_xfer = tx_ready && (cnt_q == 2'd1);

endmodule

// File: rtl/uart_cmd_bridge.sv
// Parses UART read/write commands, drives the SDRAM controller request interface
// and returns read data or a status byte to the UART transmitter.
module uart_cmd_bridge
    import sdram_uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic             clk_100MHz,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [AddrW-1:0] addr,
    output logic [DataW-1:0] wr_data,
    output logic             wr_req,
    output logic             rd_req,
    input  logic [DataW-1:0] rd_data,
    input  logic             rd_valid,
    input  logic             wr_ready,
    output logic             busy,
    output logic             rx_dropped
);

    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic [DataW-1:0] wr_data_q, wr_data_d;
    logic             is_wr_q, is_wr_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic             drop_q, drop_d;

    logic             resp_load, resp_two, resp_empty, resp_last;
    logic [7:0]       resp_b0, resp_b1;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_data_d  = wr_data_q;
        is_wr_d    = is_wr_q;
        byte_cnt_d = byte_cnt_q;
        tmo_d      = tmo_q;
        drop_d     = 1'b0;
        resp_load  = 1'b0;
        resp_two   = 1'b0;
        resp_b0    = 8'h00;
        resp_b1    = 8'h00;
        unique case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    if (rx_data == OpWrite || rx_data == OpRead) begin
                        is_wr_d    = (rx_data == OpWrite);
                        byte_cnt_d = 2'd0;
                        state_d    = StGetAddr;
                    end else begin
                        resp_load = 1'b1;
                        resp_b0   = RespUnk;
                        state_d   = StResp;
                    end
                end
            end
            StGetAddr: begin
                if (rx_valid) begin
                    addr_d     = {addr_q[15:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd2) begin
                        byte_cnt_d = 2'd0;
                        tmo_d      = '0;
                        state_d    = is_wr_q ? StGetData : StIssueRd;
                    end
                end
            end
            StGetData: begin
                if (rx_valid) begin
                    wr_data_d  = {wr_data_q[7:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd1) begin
                        byte_cnt_d = 2'd0;
                        tmo_d      = '0;
                        state_d    = StIssueWr;
                    end
                end
            end
            StIssueWr: begin
                drop_d = rx_valid;
                tmo_d  = tmo_q + TmoW'(1);
                // A completion on the final cycle wins over the timeout.
                if (wr_ready) begin
                    resp_load = 1'b1;
                    resp_b0   = RespOk;
                    state_d   = StResp;
                end else if (tmo_q == TmoLast) begin
                    resp_load = 1'b1;
                    resp_b0   = RespErr;
                    state_d   = StResp;
                end
            end
            StIssueRd: begin
                drop_d = rx_valid;
                tmo_d  = tmo_q + TmoW'(1);
                if (rd_valid) begin
                    resp_load = 1'b1;
                    resp_two  = 1'b1;
                    resp_b0   = rd_data[15:8];
                    resp_b1   = rd_data[7:0];
                    state_d   = StResp;
                end else if (tmo_q == TmoLast) begin
                    resp_load = 1'b1;
                    resp_b0   = RespErr;
                    state_d   = StResp;
                end
            end
            StResp: begin
                drop_d = rx_valid;
                if (resp_last || resp_empty) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wr_data_q  <= '0;
            is_wr_q    <= 1'b0;
            byte_cnt_q <= 2'd0;
            tmo_q      <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wr_data_q  <= wr_data_d;
            is_wr_q    <= is_wr_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_q      <= tmo_d;
            drop_q     <= drop_d;
        end
    end

    resp_tx_buf u_resp_tx_buf (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .load       (resp_load),
        .load_two   (resp_two),
        .byte0      (resp_b0),
        .byte1      (resp_b1),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .empty      (resp_empty),
        .last_xfer  (resp_last)
    );

    assign addr       = addr_q;
    assign wr_data    = wr_data_q;
    assign wr_req     = (state_q == StIssueWr);
    assign rd_req     = (state_q == StIssueRd);
    assign busy       = (state_q != StIdle);
    assign rx_dropped = drop_q;

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Randomized self-checking bench for uart_cmd_bridge against a protocol-level model.
module tb_uart_cmd_bridge;

    localparam int unsigned Tmo = 16;

    logic        clk_100MHz = 1'b0;
    logic        rst_n      = 1'b0;
    logic [7:0]  rx_data    = 8'h00;
    logic        rx_valid   = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready   = 1'b0;
    logic [23:0] addr;
    logic [15:0] wr_data;
    logic        wr_req;
    logic        rd_req;
    logic [15:0] rd_data    = 16'h0000;
    logic        rd_valid   = 1'b0;
    logic        wr_ready   = 1'b0;
    logic        busy;
    logic        rx_dropped;

    int checks   = 0;
    int failures = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    uart_cmd_bridge #(.TIMEOUT_CYCLES(Tmo)) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .addr       (addr),
        .wr_data    (wr_data),
        .wr_req     (wr_req),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .wr_ready   (wr_ready),
        .busy       (busy),
        .rx_dropped (rx_dropped)
    );

    task automatic tick();
        @(negedge clk_100MHz);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Returns at the negedge after the last byte was sampled.
    task automatic send_cmd(input logic [7:0] bytes[$], input bit gaps);
        for (int i = 0; i < bytes.size(); i++) begin
            send_byte(bytes[i]);
            if (gaps && i != bytes.size() - 1) begin
                int g = int'($urandom_range(0, 2));
                for (int j = 0; j < g; j++) tick();
            end
        end
    endtask

    task automatic collect_tx(input int n, input bit rnd, output logic [7:0] got[$]);
        got = {};
        for (int c = 0; c < 400 && got.size() < n; c++) begin
            tx_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (tx_valid && tx_ready) got.push_back(tx_data);
            tick();
        end
        tx_ready = 1'b0;
    endtask

    // Full command with the controller completing after `delay` observed request cycles.
    task automatic run_cmd(input bit is_wr, input logic [23:0] a, input logic [15:0] d,
                           input int delay, input bit rnd, input string name);
        logic [7:0] cmd[$];
        logic [7:0] exp_q[$];
        logic [7:0] got[$];
        int         high;
        cmd = {is_wr ? 8'h57 : 8'h52, a[23:16], a[15:8], a[7:0]};
        if (is_wr) begin
            cmd.push_back(d[15:8]);
            cmd.push_back(d[7:0]);
            exp_q = {8'h4B};
        end else begin
            exp_q = {d[15:8], d[7:0]};
        end
        send_cmd(cmd, 1'b1);
        checks++;
        if (wr_req !== is_wr || rd_req !== !is_wr) begin
            failures++;
            $display("FAIL %s req_start: wr_req=%b rd_req=%b expected wr_req=%b rd_req=%b",
                     name, wr_req, rd_req, is_wr, !is_wr);
        end
        checks++;
        if (addr !== a) begin
            failures++;
            $display("FAIL %s addr: got %h expected %h", name, addr, a);
        end
        if (is_wr) begin
            checks++;
            if (wr_data !== d) begin
                failures++;
                $display("FAIL %s wr_data: got %h expected %h", name, wr_data, d);
            end
        end
        high = 1;
        for (int i = 1; i < delay; i++) begin
            tick();
            if ((is_wr ? wr_req : rd_req) === 1'b1) high++;
        end
        if (is_wr) wr_ready = 1'b1;
        else begin
            rd_valid = 1'b1;
            rd_data  = d;
        end
        tick();
        wr_ready = 1'b0;
        rd_valid = 1'b0;
        rd_data  = 16'($urandom);
        checks++;
        if (high != delay || wr_req !== 1'b0 || rd_req !== 1'b0) begin
            failures++;
            $display("FAIL %s req_hold: high=%0d wr_req=%b rd_req=%b expected high=%0d reqs 0",
                     name, high, wr_req, rd_req, delay);
        end
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin
            failures++;
            $display("FAIL %s first_resp: tx_valid=%b tx_data=%h expected 1 %h",
                     name, tx_valid, tx_data, exp_q[0]);
        end
        collect_tx(exp_q.size(), rnd, got);
        checks++;
        if (got != exp_q) begin
            failures++;
            $display("FAIL %s resp_bytes: got %p expected %p", name, got, exp_q);
        end
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0 || addr !== a) begin
            failures++;
            $display("FAIL %s idle_after: busy=%b tx_valid=%b addr=%h expected 0 0 %h",
                     name, busy, tx_valid, addr, a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({tx_data, tx_valid, addr, wr_data, wr_req, rd_req, busy, rx_dropped} !== '0) begin
            failures++;
            $display("FAIL reset_values: tx_data=%h tx_valid=%b addr=%h wr_data=%h wr_req=%b rd_req=%b busy=%b rx_dropped=%b expected all 0",
                     tx_data, tx_valid, addr, wr_data, wr_req, rd_req, busy, rx_dropped);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        run_cmd(1'b1, 24'h123456, 16'hABCD, 4, 1'b0, "write");
    endtask

    task automatic test_read();
        run_cmd(1'b0, 24'h123456, 16'hBEEF, 6, 1'b0, "read");
    endtask

    task automatic test_unknown();
        logic [7:0] got[$];
        logic [7:0] op;
        for (int n = 0; n < 3; n++) begin
            op = (n == 0) ? 8'h41 : 8'($urandom);
            while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
            send_byte(op);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h3F || wr_req !== 1'b0 || rd_req !== 1'b0) begin
                failures++;
                $display("FAIL unknown_resp op=%h: tx_valid=%b tx_data=%h wr_req=%b rd_req=%b expected 1 3f 0 0",
                         op, tx_valid, tx_data, wr_req, rd_req);
            end
            collect_tx(1, 1'b1, got);
            checks++;
            if (got.size() != 1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL unknown_drain op=%h: bytes=%0d busy=%b expected 1 0",
                         op, got.size(), busy);
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] cmd[$];
        logic [7:0] got[$];
        int         high;
        cmd = {8'h52, 8'h00, 8'h01, 8'h02};
        send_cmd(cmd, 1'b0);
        high = 0;
        for (int c = 0; c < 3 * Tmo && rd_req === 1'b1; c++) begin
            high++;
            tick();
        end
        checks++;
        if (high != Tmo) begin
            failures++;
            $display("FAIL timeout_len: rd_req high %0d cycles expected %0d", high, Tmo);
        end
        checks++;
        if (rd_req !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h45) begin
            failures++;
            $display("FAIL timeout_resp: rd_req=%b tx_valid=%b tx_data=%h expected 0 1 45",
                     rd_req, tx_valid, tx_data);
        end
        collect_tx(1, 1'b0, got);
        rd_valid = 1'b1;
        rd_data  = 16'h1234;
        tick();
        rd_valid = 1'b0;
        repeat (2) tick();
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || rd_req !== 1'b0 || got.size() != 1) begin
            failures++;
            $display("FAIL timeout_late_completion: tx_valid=%b busy=%b rd_req=%b bytes=%0d expected 0 0 0 1",
                     tx_valid, busy, rd_req, got.size());
        end
    endtask

    task automatic test_drop();
        logic [7:0] cmd[$];
        logic [7:0] got[$];
        logic [7:0] exp_q[$];
        cmd   = {8'h52, 8'hA5, 8'h5A, 8'h33};
        exp_q = {8'hBE, 8'hEF};
        tx_ready = 1'b0;
        send_cmd(cmd, 1'b0);
        tick();
        rd_valid = 1'b1;
        rd_data  = 16'hBEEF;
        tick();
        rd_valid = 1'b0;
        rd_data  = 16'h0000;
        repeat (3) tick();
        send_byte(8'h52);
        checks++;
        if (rx_dropped !== 1'b1) begin
            failures++;
            $display("FAIL drop_pulse: rx_dropped=%b expected 1", rx_dropped);
        end
        tick();
        checks++;
        if (rx_dropped !== 1'b0) begin
            failures++;
            $display("FAIL drop_single: rx_dropped=%b expected 0", rx_dropped);
        end
        repeat (5) tick();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hBE || rd_req !== 1'b0 || wr_req !== 1'b0) begin
            failures++;
            $display("FAIL drop_hold: tx_valid=%b tx_data=%h rd_req=%b wr_req=%b expected 1 be 0 0",
                     tx_valid, tx_data, rd_req, wr_req);
        end
        collect_tx(2, 1'b1, got);
        checks++;
        if (got != exp_q || busy !== 1'b0 || rd_req !== 1'b0) begin
            failures++;
            $display("FAIL drop_resp: got %p busy=%b rd_req=%b expected %p 0 0",
                     got, busy, rd_req, exp_q);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] cmd[$];
        cmd = {8'h57, 8'h12};
        send_cmd(cmd, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_data, tx_valid, addr, wr_data, wr_req, rd_req, busy, rx_dropped} !== '0) begin
            failures++;
            $display("FAIL reset_mid: tx_data=%h tx_valid=%b addr=%h wr_data=%h wr_req=%b rd_req=%b busy=%b rx_dropped=%b expected all 0",
                     tx_data, tx_valid, addr, wr_data, wr_req, rd_req, busy, rx_dropped);
        end
        tick();
        rst_n = 1'b1;
        tick();
        run_cmd(1'b1, 24'hC0FFEE, 16'h1357, 3, 1'b1, "after_reset");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 16; n++) begin
            run_cmd($urandom_range(0, 1) == 1, 24'($urandom), 16'($urandom),
                    int'($urandom_range(1, 8)), 1'b1, $sformatf("random%0d", n));
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_unknown();
        test_timeout();
        test_drop();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
